// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the two-requester RAM arbiter.
package mem_arb_pkg;

  localparam int unsigned DefAddrW    = 12;
  localparam int unsigned DefDataW    = 32;
  localparam int unsigned DefMaxBurst = 8;
  localparam int unsigned DefMaxWait  = 15;

  typedef enum logic [1:0] {
    StIdle,
    StOwn0,
    StOwn1
  } arb_state_t;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

endpackage

// File: rtl/arb_wait_cnt.sv
// Saturating wait counter: counts cycles a requester is held off, flags when it hits the limit.
module arb_wait_cnt #(
  parameter int unsigned MaxWait = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic gnt_i,
  output logic at_max_o
);

  localparam int unsigned CntW = $clog2(MaxWait + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q != CntW'(MaxWait)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == CntW'(MaxWait));

endmodule

// File: rtl/mem_arb_2rq.sv
// Two-requester arbiter for a single-port synchronous RAM: same-cycle grant, burst locking,
// urgent/starvation forcing and an owner-tagged registered read return.
module mem_arb_2rq
  import mem_arb_pkg::*;
#(
  parameter int unsigned AddrW    = DefAddrW,
  parameter int unsigned DataW    = DefDataW,
  parameter int unsigned MaxBurst = DefMaxBurst,
  parameter int unsigned MaxWait  = DefMaxWait
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req0_i,
  input  logic               wr0_i,
  input  logic               lock0_i,
  input  logic [AddrW-1:0]   addr0_i,
  input  logic [DataW-1:0]   wr_data0_i,
  input  logic [DataW/8-1:0] byte_en0_i,
  output logic               gnt0_o,
  output logic               rd_valid0_o,
  output logic [DataW-1:0]   rd_data0_o,
  input  logic               req1_i,
  input  logic               wr1_i,
  input  logic               lock1_i,
  input  logic [AddrW-1:0]   addr1_i,
  input  logic [DataW-1:0]   wr_data1_i,
  input  logic [DataW/8-1:0] byte_en1_i,
  output logic               gnt1_o,
  output logic               rd_valid1_o,
  output logic [DataW-1:0]   rd_data1_o,
  input  logic               urgent1_i,
  output logic               mem_en_o,
  output logic               mem_wr_o,
  output logic [AddrW-1:0]   mem_addr_o,
  output logic [DataW-1:0]   mem_wr_data_o,
  output logic [DataW/8-1:0] mem_byte_en_o,
  input  logic [DataW-1:0]   mem_rd_data_i
);

  localparam int unsigned BurstW = $clog2(MaxBurst + 1);

  arb_state_t        state_q, state_d;
  logic [BurstW-1:0] burst_q, burst_d;
  logic              last_q, last_d;
  rd_tag_t           tag_q, tag_d;
  logic              force0, force1;
  logic              gnt0, gnt1;

  arb_wait_cnt #(.MaxWait(MaxWait)) u_wait0 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req0_i),
    .gnt_i   (gnt0),
    .at_max_o(force0)
  );

  arb_wait_cnt #(.MaxWait(MaxWait)) u_wait1 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req1_i),
    .gnt_i   (gnt1),
    .at_max_o(force1)
  );

  // A starved requester 0 outranks Urgent1 so the core cannot be locked out by the VGA.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_i) begin
      gnt0 = 1'b0;
    end else if (force0 && req0_i) begin
      gnt0 = 1'b1;
    end else if (urgent1_i && req1_i) begin
      gnt1 = 1'b1;
    end else if (force1 && req1_i) begin
      gnt1 = 1'b1;
    end else if (state_q == StOwn0 && req0_i) begin
      gnt0 = 1'b1;
    end else if (state_q == StOwn1 && req1_i) begin
      gnt1 = 1'b1;
    end else if (req0_i && req1_i) begin
      gnt0 = last_q;
      gnt1 = ~last_q;
    end else begin
      gnt0 = req0_i;
      gnt1 = req1_i;
    end
  end

  always_comb begin
    state_d = StIdle;
    burst_d = '0;
    if (gnt0 && lock0_i && state_q != StOwn1 && burst_q < BurstW'(MaxBurst - 1)) begin
      state_d = StOwn0;
      burst_d = burst_q + 1'b1;
    end else if (gnt1 && lock1_i && state_q != StOwn0 && burst_q < BurstW'(MaxBurst - 1)) begin
      state_d = StOwn1;
      burst_d = burst_q + 1'b1;
    end
    last_d = gnt1 ? 1'b1 : (gnt0 ? 1'b0 : last_q);
    tag_d.valid = (gnt0 && !wr0_i) || (gnt1 && !wr1_i);
    tag_d.owner = gnt1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      burst_q <= '0;
      last_q  <= 1'b1;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      last_q  <= last_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    mem_wr_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wr_data_o = '0;
    mem_byte_en_o = '0;
    if (gnt0) begin
      mem_wr_o      = wr0_i;
      mem_addr_o    = addr0_i;
      mem_wr_data_o = wr_data0_i;
      mem_byte_en_o = byte_en0_i;
    end else if (gnt1) begin
      mem_wr_o      = wr1_i;
      mem_addr_o    = addr1_i;
      mem_wr_data_o = wr_data1_i;
      mem_byte_en_o = byte_en1_i;
    end
  end

  assign mem_en_o    = gnt0 | gnt1;
  assign gnt0_o      = gnt0;
  assign gnt1_o      = gnt1;
  assign rd_valid0_o = tag_q.valid && !tag_q.owner;
  assign rd_valid1_o = tag_q.valid && tag_q.owner;
  assign rd_data0_o  = rd_valid0_o ? mem_rd_data_i : '0;
  assign rd_data1_o  = rd_valid1_o ? mem_rd_data_i : '0;

endmodule

// File: tb/tb_mem_arb_2rq.sv
// Directed bench for mem_arb_2rq: grant, read return, round-robin, burst, urgent, forcing, reset.
module tb_mem_arb_2rq;
  import mem_arb_pkg::*;

  logic        clk, rst;
  logic        req0, wr0, lock0, req1, wr1, lock1, urgent1;
  logic [11:0] addr0, addr1;
  logic [31:0] wdata0, wdata1, mem_rd_data;
  logic [3:0]  be0, be1;
  logic        gnt0, gnt1, rd_valid0, rd_valid1;
  logic [31:0] rd_data0, rd_data1;
  logic        mem_en, mem_wr;
  logic [11:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_byte_en;

  int n_cmp = 0;
  int n_err = 0;

  mem_arb_2rq dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req0_i       (req0),
    .wr0_i        (wr0),
    .lock0_i      (lock0),
    .addr0_i      (addr0),
    .wr_data0_i   (wdata0),
    .byte_en0_i   (be0),
    .gnt0_o       (gnt0),
    .rd_valid0_o  (rd_valid0),
    .rd_data0_o   (rd_data0),
    .req1_i       (req1),
    .wr1_i        (wr1),
    .lock1_i      (lock1),
    .addr1_i      (addr1),
    .wr_data1_i   (wdata1),
    .byte_en1_i   (be1),
    .gnt1_o       (gnt1),
    .rd_valid1_o  (rd_valid1),
    .rd_data1_o   (rd_data1),
    .urgent1_i    (urgent1),
    .mem_en_o     (mem_en),
    .mem_wr_o     (mem_wr),
    .mem_addr_o   (mem_addr),
    .mem_wr_data_o(mem_wr_data),
    .mem_byte_en_o(mem_byte_en),
    .mem_rd_data_i(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven and checked off-edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    req0 = 1'b0; wr0 = 1'b0; lock0 = 1'b0;
    req1 = 1'b0; wr1 = 1'b0; lock1 = 1'b0;
    urgent1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    addr0 = 12'h123; addr1 = 12'h000;
    wdata0 = 32'h1111_2222; wdata1 = 32'h0;
    be0 = 4'hF; be1 = 4'h0;
    mem_rd_data = 32'hDEAD_BEEF;
    req0 = 1'b1;
    #3;
    chk("rst_gnt0", 64'(gnt0), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_rd_valid0", 64'(rd_valid0), 64'd0);
    chk("rst_rd_data0", 64'(rd_data0), 64'd0);
    req0 = 1'b0;
    tick();
    rst = 1'b0;

    // Single read from requester 0
    req0 = 1'b1; wr0 = 1'b0; addr0 = 12'h010;
    #1;
    chk("rd_gnt0", 64'(gnt0), 64'd1);
    chk("rd_gnt1", 64'(gnt1), 64'd0);
    chk("rd_mem_en", 64'(mem_en), 64'd1);
    chk("rd_mem_wr", 64'(mem_wr), 64'd0);
    chk("rd_mem_addr", 64'(mem_addr), 64'h010);
    tick();
    req0 = 1'b0;
    #1;
    chk("rd_valid0", 64'(rd_valid0), 64'd1);
    chk("rd_data0", 64'(rd_data0), 64'hDEAD_BEEF);
    chk("rd_valid1_quiet", 64'(rd_valid1), 64'd0);
    chk("rd_data1_quiet", 64'(rd_data1), 64'd0);
    chk("idle_mem_en", 64'(mem_en), 64'd0);
    chk("idle_mem_addr", 64'(mem_addr), 64'd0);
    tick();
    chk("rd_valid0_once", 64'(rd_valid0), 64'd0);

    // Write from requester 1: fields muxed, no read return
    req1 = 1'b1; wr1 = 1'b1; addr1 = 12'h3FF; wdata1 = 32'hCAFE_0001; be1 = 4'hA;
    #1;
    chk("wr_gnt1", 64'(gnt1), 64'd1);
    chk("wr_mem_wr", 64'(mem_wr), 64'd1);
    chk("wr_mem_addr", 64'(mem_addr), 64'h3FF);
    chk("wr_mem_wdata", 64'(mem_wr_data), 64'hCAFE_0001);
    chk("wr_mem_be", 64'(mem_byte_en), 64'hA);
    tick();
    idle_all();
    #1;
    chk("wr_no_rd_valid1", 64'(rd_valid1), 64'd0);
    tick();

    // Round robin with both requesting, last grant was to 1
    req0 = 1'b1; req1 = 1'b1; wr1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_gnt0_%0d", i), 64'(gnt0), 64'((i % 2) == 0));
      chk($sformatf("rr_gnt1_%0d", i), 64'(gnt1), 64'((i % 2) == 1));
      tick();
    end

    // Locked burst by 0 is released after MaxBurst grants
    lock0 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk($sformatf("burst_gnt0_%0d", i), 64'(gnt0), 64'(i < 8));
      chk($sformatf("burst_gnt1_%0d", i), 64'(gnt1), 64'(i == 8));
      tick();
    end
    idle_all();
    tick();

    // Urgent1 breaks a locked burst
    req0 = 1'b1; lock0 = 1'b1;
    tick(); tick(); tick();
    chk("burst_own0", 64'(dut.state_q), 64'(StOwn0));
    req1 = 1'b1; urgent1 = 1'b1;
    #1;
    chk("urg_gnt1", 64'(gnt1), 64'd1);
    chk("urg_gnt0", 64'(gnt0), 64'd0);
    tick();
    chk("urg_state_idle", 64'(dut.state_q), 64'(StIdle));
    chk("urg_burst_zero", 64'(dut.burst_q), 64'd0);
    idle_all();
    tick();

    // Urgent1 held: requester 0 forced after waiting MaxWait cycles
    req0 = 1'b1; req1 = 1'b1; urgent1 = 1'b1;
    for (int i = 0; i < 17; i++) begin
      #1;
      chk($sformatf("force_gnt0_%0d", i), 64'(gnt0), 64'(i == 15));
      chk($sformatf("force_gnt1_%0d", i), 64'(gnt1), 64'(i != 15));
      tick();
    end
    idle_all();
    tick();

    // Reset in the cycle after a read grant drops the pending return
    req0 = 1'b1; wr0 = 1'b0; addr0 = 12'h055;
    #1;
    chk("rr_gnt0_pre_rst", 64'(gnt0), 64'd1);
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_rd_valid0", 64'(rd_valid0), 64'd0);
    chk("mid_rst_rd_data0", 64'(rd_data0), 64'd0);
    chk("mid_rst_gnt0", 64'(gnt0), 64'd0);
    chk("mid_rst_mem_en", 64'(mem_en), 64'd0);
    tick();
    rst = 1'b0;
    req0 = 1'b0;
    #1;
    chk("post_rst_rd_valid0", 64'(rd_valid0), 64'd0);
    req0 = 1'b1; req1 = 1'b1;
    #1;
    chk("post_rst_gnt0", 64'(gnt0), 64'd1);
    chk("post_rst_gnt1", 64'(gnt1), 64'd0);
    tick();
    chk("post_rst_next_gnt1", 64'(gnt1), 64'd1);
    idle_all();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
